// File: rtl/ecg_peak_detect_if.sv
// ecg_peak_detect_if: sample stream in, beat/R-R/BPM results out.
// The master side feeds samples and the threshold. The slave side is the detector.
interface ecg_peak_detect_if #(
    parameter int unsigned RR_W = 16
);
    logic [15:0]     sample_in;
    logic            sample_valid;
    logic [15:0]     threshold;
    logic            beat;
    logic [15:0]     peak_value;
    logic [RR_W-1:0] rr_interval;
    logic            rr_valid;
    logic [7:0]      bpm;
    logic            bpm_valid;

    modport master (
        output sample_in, sample_valid, threshold,
        input  beat, peak_value, rr_interval, rr_valid, bpm, bpm_valid
    );

    modport slave (
        input  sample_in, sample_valid, threshold,
        output beat, peak_value, rr_interval, rr_valid, bpm, bpm_valid
    );
endinterface

// File: rtl/ecg_peak_detect.sv
// ecg_peak_detect: R-peak detector for the ECG sample stream.
// The detector uses a threshold/refractory FSM (ARM -> SEARCH -> TRACK -> REFRACT).
// It reports the peak amplitude and the R-R interval in samples.
// Optional macro ECG_BPM_DIV_EN adds a 16-cycle restoring divider.
// The divider converts the R-R interval to beats per minute.
module ecg_peak_detect #(
    parameter int unsigned RR_W           = 16,
    parameter int unsigned REFRACT        = 50,
    parameter int unsigned SAMPLE_RATE_HZ = 500
) (
    input  logic              clk,
    input  logic              reset_n,
    ecg_peak_detect_if.slave  bus
);

    localparam int unsigned RC_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

    // The BPM numerator must fit the 16-bit dividend.
    if (60 * SAMPLE_RATE_HZ >= 65536) begin : g_bad_rate
        $error("ecg_peak_detect: 60*SAMPLE_RATE_HZ must be below 65536");
    end

    typedef enum logic [1:0] {
        ST_ARM,
        ST_SEARCH,
        ST_TRACK,
        ST_REFRACT
    } state_e;

    state_e                 state_q, state_d;
    logic signed [15:0]     max_q, max_d;
    logic [RC_W-1:0]        rc_q, rc_d;
    logic [RR_W-1:0]        rr_cnt_q, rr_cnt_d;
    logic                   have_beat_q, have_beat_d;
    logic [15:0]            peak_q, peak_d;
    logic [RR_W-1:0]        rr_interval_q, rr_interval_d;
    logic                   beat_q, beat_d;
    logic                   rr_valid_q, rr_valid_d;

    logic signed [15:0]     sample_s;
    logic signed [15:0]     thr_s;
    logic                   below_c;
    logic [RR_W-1:0]        rr_inc_c;

    assign sample_s = bus.sample_in;
    assign thr_s    = bus.threshold;
    assign below_c  = (sample_s < thr_s);
    assign rr_inc_c = (rr_cnt_q == '1) ? rr_cnt_q : rr_cnt_q + RR_W'(1);

    // Detector state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ARM;
            max_q         <= '0;
            rc_q          <= '0;
            rr_cnt_q      <= '0;
            have_beat_q   <= 1'b0;
            peak_q        <= '0;
            rr_interval_q <= '0;
            beat_q        <= 1'b0;
            rr_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_q         <= max_d;
            rc_q          <= rc_d;
            rr_cnt_q      <= rr_cnt_d;
            have_beat_q   <= have_beat_d;
            peak_q        <= peak_d;
            rr_interval_q <= rr_interval_d;
            beat_q        <= beat_d;
            rr_valid_q    <= rr_valid_d;
        end
    end

    // Next-state logic; everything advances only on valid samples.
    always_comb begin
        state_d       = state_q;
        max_d         = max_q;
        rc_d          = rc_q;
        rr_cnt_d      = rr_cnt_q;
        have_beat_d   = have_beat_q;
        peak_d        = peak_q;
        rr_interval_d = rr_interval_q;
        beat_d        = 1'b0;
        rr_valid_d    = 1'b0;

        if (bus.sample_valid) begin
            rr_cnt_d = rr_inc_c;
            unique case (state_q)
                ST_ARM: begin
                    // Start-up high input must first drop below threshold.
                    if (below_c) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (!below_c) begin
                        max_d   = sample_s;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!below_c) begin
                        if (sample_s > max_q) max_d = sample_s;
                    end else begin
                        peak_d      = max_q;
                        beat_d      = 1'b1;
                        rr_cnt_d    = '0;
                        have_beat_d = 1'b1;
                        if (have_beat_q) begin
                            rr_interval_d = rr_inc_c;
                            rr_valid_d    = 1'b1;
                        end
                        if (REFRACT == 0) begin
                            state_d = ST_ARM;
                        end else begin
                            rc_d    = RC_W'(REFRACT);
                            state_d = ST_REFRACT;
                        end
                    end
                end
                ST_REFRACT: begin
                    if (rc_q <= RC_W'(1)) begin
                        rc_d    = '0;
                        state_d = ST_ARM;
                    end else begin
                        rc_d = rc_q - RC_W'(1);
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end
    end

    assign bus.beat        = beat_q;
    assign bus.peak_value  = peak_q;
    assign bus.rr_interval = rr_interval_q;
    assign bus.rr_valid    = rr_valid_q;

`ifdef ECG_BPM_DIV_EN
    localparam logic [15:0] BPM_NUM = 16'(60 * SAMPLE_RATE_HZ);

    logic              div_busy_q, div_busy_d;
    logic [4:0]        div_cnt_q, div_cnt_d;
    logic [RR_W-1:0]   div_rem_q, div_rem_d;
    logic [RR_W-1:0]   div_dvs_q, div_dvs_d;
    logic [15:0]       div_quo_q, div_quo_d;
    logic [7:0]        bpm_q, bpm_d;
    logic              bpm_valid_q, bpm_valid_d;
    logic [RR_W:0]     trial_c;
    logic              take_c;

    // Divider state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_busy_q  <= 1'b0;
            div_cnt_q   <= '0;
            div_rem_q   <= '0;
            div_dvs_q   <= '0;
            div_quo_q   <= '0;
            bpm_q       <= '0;
            bpm_valid_q <= 1'b0;
        end else begin
            div_busy_q  <= div_busy_d;
            div_cnt_q   <= div_cnt_d;
            div_rem_q   <= div_rem_d;
            div_dvs_q   <= div_dvs_d;
            div_quo_q   <= div_quo_d;
            bpm_q       <= bpm_d;
            bpm_valid_q <= bpm_valid_d;
        end
    end

    // Restoring division: one quotient bit per cycle. A new interval restarts the division.
    always_comb begin
        div_busy_d  = div_busy_q;
        div_cnt_d   = div_cnt_q;
        div_rem_d   = div_rem_q;
        div_dvs_d   = div_dvs_q;
        div_quo_d   = div_quo_q;
        bpm_d       = bpm_q;
        bpm_valid_d = 1'b0;

        trial_c = {div_rem_q, div_quo_q[15]};
        take_c  = (trial_c >= {1'b0, div_dvs_q});

        if (rr_valid_q) begin
            div_busy_d = 1'b1;
            div_cnt_d  = 5'd16;
            div_rem_d  = '0;
            div_quo_d  = BPM_NUM;
            div_dvs_d  = rr_interval_q;
        end else if (div_busy_q) begin
            div_rem_d = take_c ? RR_W'(trial_c - {1'b0, div_dvs_q}) : RR_W'(trial_c);
            div_quo_d = {div_quo_q[14:0], take_c};
            div_cnt_d = div_cnt_q - 5'd1;
            if (div_cnt_q == 5'd1) begin
                div_busy_d  = 1'b0;
                bpm_valid_d = 1'b1;
                bpm_d       = (div_quo_d > 16'd255) ? 8'hFF : div_quo_d[7:0];
            end
        end
    end

    assign bus.bpm       = bpm_q;
    assign bus.bpm_valid = bpm_valid_q;
`else
    assign bus.bpm       = '0;
    assign bus.bpm_valid = 1'b0;
`endif

endmodule

// File: doc/ecg_peak_detect.md
# ecg_peak_detect

Downstream consumer of the ECG ROM playback stage: takes the 16-bit signed sample stream and detects R-peaks with a threshold/refractory state machine. Outputs a one-cycle beat pulse, the peak amplitude and the R-R interval in samples. Optionally adds a sequential divider that converts the R-R interval to beats per minute. It drives the heart-rate display and alarm logic.

## Interface
- `RR_W`, 16: R-R counter and `rr_interval` width.
- `REFRACT`, 50: refractory length in accepted samples after each beat.
- `SAMPLE_RATE_HZ`, 500: sample rate used by the BPM divider; `60*SAMPLE_RATE_HZ` must be below 2^16.

- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sample_in`  in  16: signed ECG sample, same format as the playback stage output.
- `sample_valid`  in  1: qualifies `sample_in` for one cycle. All state advances only on cycles where it is high.
- `threshold`  in  16: signed detection threshold. Sampled on every valid sample and may change at any time.
- `beat`  out  1: one-cycle pulse on peak confirmation.
- `peak_value`  out  16: signed maximum of the last confirmed peak. Held until the next beat.
- `rr_interval`  out  RR_W: samples between the last two beats. Held.
- `rr_valid`  out  1: one-cycle pulse when `rr_interval` updates.
- `bpm`  out  8: heart rate, saturated at 255.
- `bpm_valid`  out  1: one-cycle pulse when `bpm` updates.

## Operation
States, with transitions evaluated only on valid samples:
- ARM (reset state): if `sample_in < threshold`, go to SEARCH. This blocks false triggers when the input starts high.
- SEARCH: if `sample_in >= threshold`, load `max_r <= sample_in` and go to TRACK.
- TRACK: if `sample_in >= threshold`, update `max_r` to `max(max_r, sample_in)` and stay.
  - If `sample_in < threshold`, confirm the peak: `peak_value <= max_r`, pulse `beat`, load the refractory counter with `REFRACT`, and go to REFRACT.
- REFRACT: decrement the counter on each valid sample. When it reaches 0, go to ARM. With `REFRACT=0`, go directly to ARM.

R-R counter `rr_cnt` (RR_W bits):
- Increments on every valid sample and saturates at all-ones.
- On the beat-confirming sample:
  - `rr_cnt <= 0`.
  - If a previous beat exists since reset: `rr_interval <= sat(rr_cnt+1)` and pulse `rr_valid`.
  - The first beat after reset produces `beat` but no `rr_valid`.

Comparisons are signed 16-bit throughout. A threshold change during TRACK takes effect on the next valid sample.

## Timing
- Reset values: state ARM, `beat=0`, `peak_value=0`, `rr_interval=0`, `rr_valid=0`, `bpm=0`, `bpm_valid=0`, `rr_cnt=0`, first-beat flag clear, divider idle.
- `beat`, `rr_valid`, `peak_value` and `rr_interval` are registered. They assert/update in the cycle after the `sample_valid` cycle whose sample fell below threshold, and pulses last exactly one cycle.
- Back-to-back valid samples on every cycle are supported with no stalls.
- Reset asserted mid-operation clears everything immediately, including an in-flight division. No pulse is emitted during reset or on the release cycle.
- BPM divider:
  - Starts on the `rr_valid` cycle.
  - Takes 16 cycles, 1 quotient bit per cycle (restoring).
  - `bpm` and `bpm_valid` update 17 cycles after `rr_valid`.
  - If a new `rr_valid` arrives while busy, the current division is abandoned and restarts with the new interval; no `bpm_valid` is issued for the abandoned one.

## Configuration
- `ECG_BPM_DIV_EN` defined: the divider computes `bpm = min(255, (60*SAMPLE_RATE_HZ) / rr_interval)`. `rr_interval` is always at least 1, so no divide-by-zero.
- `ECG_BPM_DIV_EN` undefined: no divider logic. `bpm` is tied to 0 and `bpm_valid` to 0. All other behaviour is identical.

## Test plan
- Reset with `sample_in=2000`, `threshold=1000`, valid every cycle. Then 10 samples at 2000, then 0 -> no `beat` (ARM blocks); all outputs 0.
- Baseline 0. Pulse 1200, 1800, 1500, then 0 with `threshold=1000` -> `beat` one cycle after the 0 sample; `peak_value=1800`; no `rr_valid` (first beat).
- Beats confirmed at valid-sample indices 100 and 600 -> `rr_interval=500` with `rr_valid`. With `ECG_BPM_DIV_EN` and `SAMPLE_RATE_HZ=500`: `bpm=60`, with `bpm_valid` 17 cycles after `rr_valid`.
- Second pulse arrives 20 samples after a beat (`REFRACT=50`) -> ignored. A pulse 80 samples after the beat is detected, giving `rr_interval=80` and `bpm=255` (saturated from 375).
- `sample_valid` held low for 1000 cycles mid-TRACK -> state, `max_r` and `rr_cnt` frozen; detection resumes correctly when valid returns.
- `reset_n` pulsed low in the cycle after `rr_valid` (divider busy) -> `bpm_valid` never asserts; all outputs read 0.
